i2c_frame_target: RTL and testbench

I2C_FRAME_TARGET -- requirements
Module: i2c_frame_target

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_sync_edge.sv | 41 ++++
 rtl/i2c_frame_target.sv | 197 +++++++++++++++++++
 tb/tb_i2c_frame_target.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Constants shared by the I2C frame master and target.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

    localparam logic [6:0] c_DEFAULT_ADDRESS     = 7'b0001101;
    localparam int         c_DEFAULT_FRAME_BYTES = 13;

    localparam int                   c_STATE_W     = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_ADDR     = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_ADDR_ACK = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DATA     = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DATA_ACK = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_IGNORE   = 3'd5;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
// Module      : i2c_sync_edge
// Description : 2-FF synchronizer with single-clk rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle bus level is high, so everything resets to 1 to avoid false edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/i2c_frame_target.sv
// ============================================================================
// Module      : i2c_frame_target
// Description : Write-only I2C target collecting fixed-length frames.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_frame_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = c_DEFAULT_ADDRESS,
    parameter int         FRAME_BYTES = c_DEFAULT_FRAME_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i2c_scl,
    inout  wire                      i2c_sda,
    output logic [8*FRAME_BYTES-1:0] data_out,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     busy,
    output logic [3:0]               byte_count
);

    localparam int         c_W         = 8 * FRAME_BYTES;
    localparam logic [3:0] c_FRAME_CNT = 4'(FRAME_BYTES);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    logic [c_STATE_W-1:0] r_state,       w_state_nxt;
    logic [2:0]           r_bit_cnt,     w_bit_cnt_nxt;
    logic [7:0]           r_shift,       w_shift_nxt;
    logic [c_W-1:0]       r_frame,       w_frame_nxt;
    logic [3:0]           r_byte_count,  w_byte_count_nxt;
    logic                 r_overrun,     w_overrun_nxt;
    logic                 r_busy,        w_busy_nxt;
    logic                 r_sda_oe,      w_sda_oe_nxt;
    logic [c_W-1:0]       r_data_out,    w_data_out_nxt;
    logic                 r_frame_valid, w_frame_valid_nxt;
    logic                 r_frame_err,   w_frame_err_nxt;

    i2c_sync_edge u_sync_scl (
        .clk     (clk),
        .rst     (rst),
        .i_async (i2c_scl),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_sync_edge u_sync_sda (
        .clk     (clk),
        .rst     (rst),
        .i_async (i2c_sda),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {r_shift[6:0], w_sda};

    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_shift_nxt       = r_shift;
        w_frame_nxt       = r_frame;
        w_byte_count_nxt  = r_byte_count;
        w_overrun_nxt     = r_overrun;
        w_busy_nxt        = r_busy;
        w_sda_oe_nxt      = r_sda_oe;
        w_data_out_nxt    = r_data_out;
        w_frame_valid_nxt = 1'b0;
        w_frame_err_nxt   = 1'b0;

        if (w_stop) begin
            w_state_nxt   = c_ST_IDLE;
            w_bit_cnt_nxt = 3'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            // A NACKed extra byte makes an otherwise full frame malformed.
            if (r_busy) begin
                if (r_byte_count == c_FRAME_CNT && !r_overrun) begin
                    w_data_out_nxt    = r_frame;
                    w_frame_valid_nxt = 1'b1;
                end else begin
                    w_frame_err_nxt = 1'b1;
                end
            end
        end else if (w_start) begin
            w_state_nxt      = c_ST_ADDR;
            w_bit_cnt_nxt    = 3'd0;
            w_shift_nxt      = 8'd0;
            w_byte_count_nxt = 4'd0;
            w_overrun_nxt    = 1'b0;
            w_sda_oe_nxt     = 1'b0;
            w_busy_nxt       = 1'b0;
            w_frame_err_nxt  = r_busy;
        end else begin
            case (r_state)
                c_ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = 3'(r_bit_cnt + 3'd1);
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte == {ADDRESS, 1'b0}) begin
                                w_state_nxt = c_ST_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = c_ST_IGNORE;
                            end
                        end
                    end
                end
                // First SCL fall starts the ACK drive, the second ends it.
                c_ST_ADDR_ACK, c_ST_DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 3'd0;
                            w_state_nxt   = c_ST_DATA;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = 3'(r_bit_cnt + 3'd1);
                        if (r_bit_cnt == 3'd7) begin
                            if (r_byte_count < c_FRAME_CNT) begin
                                w_frame_nxt      = (r_frame << 8) | {{(c_W-8){1'b0}}, w_byte};
                                w_byte_count_nxt = (r_byte_count == 4'hF) ? r_byte_count
                                                                          : r_byte_count + 4'd1;
                                w_state_nxt      = c_ST_DATA_ACK;
                            end else begin
                                w_overrun_nxt = 1'b1;
                                w_state_nxt   = c_ST_IGNORE;
                            end
                        end
                    end
                end
                c_ST_IDLE, c_ST_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = c_ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'd0;
            r_frame       <= '0;
            r_byte_count  <= 4'd0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_data_out    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_frame       <= w_frame_nxt;
            r_byte_count  <= w_byte_count_nxt;
            r_overrun     <= w_overrun_nxt;
            r_busy        <= w_busy_nxt;
            r_sda_oe      <= w_sda_oe_nxt;
            r_data_out    <= w_data_out_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_frame_err   <= w_frame_err_nxt;
        end
    end

    assign i2c_sda     = r_sda_oe ? 1'b0 : 1'bz;
    assign data_out    = r_data_out;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign busy        = r_busy;
    assign byte_count  = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_i2c_frame_target.sv
// ============================================================================
// Module      : tb_i2c_frame_target
// Description : Self-checking bench with a bit-banged I2C master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_frame_target;
    import i2c_pkg::*;

    localparam int FB = c_DEFAULT_FRAME_BYTES;
    localparam int W  = 8 * FB;
    localparam int Q  = 5;
    localparam logic [103:0] c_SPEC_FRAME = 104'h1113556789012345678901234;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    logic [W-1:0] data_out;
    logic         frame_valid;
    logic         frame_err;
    logic         busy;
    logic [3:0]   byte_count;

    int compared = 0;
    int mismatched = 0;
    int valid_cyc = 0;
    int err_cyc = 0;
    int both_cyc = 0;
    int tlow_cyc = 0;

    logic [7:0]   tx [0:15];
    logic [W-1:0] exp_data = '0;

    typedef struct {
        logic [7:0] addr;
        int         nbytes;
        logic       aack;
        int         nacks;
        int         v;
        int         e;
        logic [3:0] bc;
    } vec_t;
    vec_t tbl [7];

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_frame_target dut (
        .clk         (clk),
        .rst         (rst),
        .i2c_scl     (scl),
        .i2c_sda     (sda),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .byte_count  (byte_count)
    );

    always @(negedge clk) begin
        if (frame_valid === 1'b1) valid_cyc++;
        if (frame_err === 1'b1) err_cyc++;
        if (frame_valid === 1'b1 && frame_err === 1'b1) both_cyc++;
        if (!m_sda_low && sda === 1'b0) tlow_cyc++;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_rstart();
        m_sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b0;
        wait_clk(4 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i];
            wait_clk(Q);
            scl = 1'b1;
            wait_clk(2 * Q);
            scl = 1'b0;
            wait_clk(Q);
        end
        m_sda_low = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        ack = (sda === 1'b0);
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    // Sends tx[0..n-1]; the target should ACK exactly the first nacks bytes.
    task automatic send_data(input int n, input int nacks);
        logic ack;
        for (int i = 0; i < n; i++) begin
            send_byte(tx[i], ack);
            check("data_ack", W'(ack), W'(i < nacks));
        end
    endtask

    // Reference: a write to our address ACKs up to FB bytes; exactly FB bytes makes a frame.
    function automatic void model(input logic [7:0] a, input int n, output logic aack,
                                  output int nacks, output int v, output int e,
                                  output logic [3:0] bc);
        aack  = (a == {c_DEFAULT_ADDRESS, 1'b0});
        nacks = aack ? ((n < FB) ? n : FB) : 0;
        bc    = 4'(nacks);
        v     = (aack && n == FB) ? 1 : 0;
        e     = (aack && n != FB) ? 1 : 0;
    endfunction

    task automatic expect_frame();
        for (int i = 0; i < FB; i++) exp_data[W-1-8*i -: 8] = tx[i];
    endtask

    task automatic run_xfer(input logic [7:0] a, input int n, input logic e_aack, input int e_nacks,
                            input int e_v, input int e_e, input logic [3:0] e_bc);
        int   v0, e0, b0, t0;
        logic ack;
        v0 = valid_cyc;
        e0 = err_cyc;
        b0 = both_cyc;
        t0 = tlow_cyc;
        bus_start();
        send_byte(a, ack);
        check("addr_ack", W'(ack), W'(e_aack));
        check("busy_after_addr", W'(busy), W'(e_aack));
        send_data(n, e_nacks);
        check("byte_count", W'(byte_count), W'(e_bc));
        bus_stop();
        if (e_v != 0) expect_frame();
        check("frame_valid_cycles", W'(valid_cyc - v0), W'(e_v));
        check("frame_err_cycles", W'(err_cyc - e0), W'(e_e));
        check("data_out", data_out, exp_data);
        check("busy_after_stop", W'(busy), W'(0));
        check("valid_and_err_same_cycle", W'(both_cyc - b0), W'(0));
        if (!e_aack) check("target_pulled_sda", W'(tlow_cyc - t0), W'(0));
    endtask

    initial begin
        logic [103:0] spec_v;
        logic         m_aack;
        logic [3:0]   m_bc;
        int           m_nacks, m_v, m_e, v0, e0;
        logic [7:0]   ra;
        int           rn;
        logic         ack;

        spec_v = c_SPEC_FRAME;
        tbl[0] = '{8'h1A, 13, 1'b1, 13, 1, 0, 4'd13};
        tbl[1] = '{8'h54,  3, 1'b0,  0, 0, 0, 4'd0};
        tbl[2] = '{8'h1B,  2, 1'b0,  0, 0, 0, 4'd0};
        tbl[3] = '{8'h1A,  5, 1'b1,  5, 0, 1, 4'd5};
        tbl[4] = '{8'h1A, 14, 1'b1, 13, 0, 1, 4'd13};
        tbl[5] = '{8'h1A,  0, 1'b1,  0, 0, 1, 4'd0};
        tbl[6] = '{8'h1A, 13, 1'b1, 13, 1, 0, 4'd13};

        // Reset state
        wait_clk(3);
        check("rst_data_out", data_out, '0);
        check("rst_frame_valid", W'(frame_valid), W'(0));
        check("rst_frame_err", W'(frame_err), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_byte_count", W'(byte_count), W'(0));
        check("rst_sda", W'(sda), W'(1));
        rst = 1'b1;
        wait_clk(4 * Q);

        // Table-driven transactions on the reference frame contents
        for (int i = 0; i < FB; i++) tx[i] = spec_v[103-8*i -: 8];
        tx[13] = 8'hA5;
        for (int k = 0; k < 7; k++) begin
            run_xfer(tbl[k].addr, tbl[k].nbytes, tbl[k].aack, tbl[k].nacks,
                     tbl[k].v, tbl[k].e, tbl[k].bc);
        end
        check("spec_frame_value", data_out, W'(c_SPEC_FRAME));

        // Randomized transactions against the reference model
        for (int k = 0; k < 8; k++) begin
            ra = ($urandom_range(0, 3) != 0) ? 8'h1A : 8'($urandom);
            rn = $urandom_range(0, 14);
            for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
            model(ra, rn, m_aack, m_nacks, m_v, m_e, m_bc);
            run_xfer(ra, rn, m_aack, m_nacks, m_v, m_e, m_bc);
        end

        // Repeated START while busy aborts, then a full frame succeeds
        for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
        v0 = valid_cyc;
        e0 = err_cyc;
        bus_start();
        send_byte(8'h1A, ack);
        check("rs_addr_ack", W'(ack), W'(1));
        send_data(3, 3);
        bus_rstart();
        check("rs_abort_err", W'(err_cyc - e0), W'(1));
        check("rs_busy_cleared", W'(busy), W'(0));
        check("rs_byte_count_cleared", W'(byte_count), W'(0));
        send_byte(8'h1A, ack);
        check("rs_addr_ack2", W'(ack), W'(1));
        send_data(FB, FB);
        bus_stop();
        expect_frame();
        check("rs_valid", W'(valid_cyc - v0), W'(1));
        check("rs_err_total", W'(err_cyc - e0), W'(1));
        check("rs_data_out", data_out, exp_data);

        // Repeated START out of IGNORE carries no error
        for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
        v0 = valid_cyc;
        e0 = err_cyc;
        bus_start();
        send_byte(8'h54, ack);
        check("ig_addr_nack", W'(ack), W'(0));
        bus_rstart();
        send_byte(8'h1A, ack);
        check("ig_addr_ack", W'(ack), W'(1));
        send_data(FB, FB);
        bus_stop();
        expect_frame();
        check("ig_err", W'(err_cyc - e0), W'(0));
        check("ig_valid", W'(valid_cyc - v0), W'(1));
        check("ig_data_out", data_out, exp_data);

        // Reset during the ACK of byte 6 releases SDA without a clock edge
        bus_start();
        send_byte(8'h1A, ack);
        send_data(5, 5);
        send_bits(tx[5]);
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        #2;
        check("ack6_driven", W'(sda), W'(0));
        rst = 1'b0;
        #1;
        check("ack6_sda_released_async", W'(sda), W'(1));
        @(negedge clk);
        exp_data = '0;
        check("ack6_rst_busy", W'(busy), W'(0));
        check("ack6_rst_byte_count", W'(byte_count), W'(0));
        check("ack6_rst_data_out", data_out, exp_data);
        wait_clk(Q - 1);
        scl = 1'b0;
        wait_clk(Q);
        bus_stop();
        rst = 1'b1;
        wait_clk(4 * Q);
        for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
        run_xfer(8'h1A, FB, 1'b1, FB, 1, 0, 4'(FB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
